// File: rtl/maxpool2x2_stream_if.sv
// Valid/ready stream bundle used on both sides of the 2x2 max-pool block.
// The source side carries no frame marker, so last appears only on the master modport.
interface maxpool2x2_stream_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-ordered H x W map.
// Even rows leave per-column-pair partial maxima in a line buffer; odd rows finish them.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 4,
  parameter int W          = 4,
  parameter int D          = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  maxpool2x2_stream_if.slave    in_s,
  maxpool2x2_stream_if.master   out_s
);

  localparam int PW = DATA_WIDTH * D;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int LD = W / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;

  typedef enum logic {EVEN_ROW, ODD_ROW} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [PW-1:0]   hp;
  logic [PW-1:0]   linebuf [LD];
  logic [LW-1:0]   lidx;
  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            completes;
  logic [PW-1:0]   pair_max;
  logic [PW-1:0]   pool_max;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // Stall only while an output is waiting, even if this beat would not produce one.
  assign in_s.ready = !out_s.valid || out_s.ready;
  assign accept     = in_s.valid && in_s.ready;
  assign col_last   = (col == CW'(W - 1));
  assign row_last   = (row == RW'(H - 1));
  assign lidx       = LW'(col >> 1);
  assign completes  = accept && col[0] && (state == ODD_ROW);

  always_comb begin
    pair_max = '0;
    pool_max = '0;
    for (int d = 0; d < D; d++) begin
      pair_max[d*DATA_WIDTH +: DATA_WIDTH] = smax(hp[d*DATA_WIDTH +: DATA_WIDTH],
                                                  in_s.data[d*DATA_WIDTH +: DATA_WIDTH]);
      pool_max[d*DATA_WIDTH +: DATA_WIDTH] = smax(linebuf[lidx][d*DATA_WIDTH +: DATA_WIDTH],
                                                  pair_max[d*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    state_next = state;
    if (accept && col_last) begin
      if (row_last)
        state_next = EVEN_ROW;
      else
        state_next = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EVEN_ROW;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // A new completing beat in the same cycle as acceptance keeps valid high with fresh data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_s.valid <= 1'b0;
      out_s.data  <= '0;
      out_s.last  <= 1'b0;
    end else if (completes) begin
      out_s.valid <= 1'b1;
      out_s.data  <= pool_max;
      out_s.last  <= row_last && col_last;
    end else if (out_s.ready) begin
      out_s.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col[0])
        hp <= in_s.data;
      else if (state == EVEN_ROW)
        linebuf[lidx] <= pair_max;
    end
  end

endmodule
